// File: rtl/vga_vram_fetcher.sv
// vga_vram_fetcher: walks the framebuffer over a four-phase req/ready read port into a FIFO,
// drained LSB-first by a 1-bit-per-pixel serializer under the pixel strobe.
module vga_vram_fetcher #(
    parameter int          FRAME_WORDS = 24576,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [14:0] BASE_ADDR   = 15'd0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          frame_start,
    input  logic                          pixel_en,
    output logic [14:0]                   vram_vga_addr,
    output logic                          vram_vga_req,
    input  logic [31:0]                   vram_vga_data_out,
    input  logic                          vram_vga_ready,
    output logic                          pixel,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(FRAME_WORDS + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_LOW} state_t;

    state_t        state_q;
    logic          req_q, discard_q;
    logic [14:0]   addr_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [LW-1:0] level_q;
    logic [31:0]   sh_q;
    logic [4:0]    sh_cnt_q;
    logic          pixel_q, underrun_q;
    logic          start, push, pop, flush;
    logic [31:0]   head;

    // A new request also waits for ready to fall, so req never rises while ready is still high.
    always_comb begin
        head  = mem_q[rd_q];
        start = state_q == IDLE && enable && !frame_start && !vram_vga_ready &&
                cnt_q < CW'(FRAME_WORDS) && level_q < LW'(FIFO_DEPTH);
        push  = state_q == REQ && vram_vga_ready && !discard_q && !frame_start;
        flush = (state_q == IDLE && frame_start) ||
                (state_q == WAIT_LOW && !vram_vga_ready && (discard_q || frame_start));
        pop   = pixel_en && !frame_start && sh_cnt_q == 5'd0 && level_q != '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            addr_q    <= BASE_ADDR;
            cnt_q     <= '0;
            discard_q <= 1'b0;
        end else begin
            if (state_q != IDLE && frame_start)
                discard_q <= 1'b1;
            case (state_q)
                IDLE: if (start) begin
                    state_q <= REQ;
                    req_q   <= 1'b1;
                end
                REQ: if (vram_vga_ready) begin
                    state_q <= WAIT_LOW;
                    req_q   <= 1'b0;
                    if (push) begin
                        addr_q <= addr_q + 15'd1;
                        cnt_q  <= cnt_q + CW'(1);
                    end
                end
                WAIT_LOW: if (!vram_vga_ready)
                    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if (flush) begin
                addr_q    <= BASE_ADDR;
                cnt_q     <= '0;
                discard_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_q] <= vram_vga_data_out;
        if (!reset_n || flush) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            wr_q    <= wr_q + AW'(push);
            rd_q    <= rd_q + AW'(pop);
            level_q <= level_q + LW'(push) - LW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || frame_start) begin
            sh_q       <= '0;
            sh_cnt_q   <= '0;
            pixel_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else if (pixel_en) begin
            if (sh_cnt_q != 5'd0) begin
                pixel_q  <= sh_q[0];
                sh_q     <= sh_q >> 1;
                sh_cnt_q <= sh_cnt_q - 5'd1;
            end else if (level_q != '0) begin
                pixel_q  <= head[0];
                sh_q     <= head >> 1;
                sh_cnt_q <= 5'd31;
            end else begin
                pixel_q    <= 1'b0;
                underrun_q <= 1'b1;
            end
        end
    end

    assign vram_vga_addr = addr_q;
    assign vram_vga_req  = req_q;
    assign pixel         = pixel_q;
    assign underrun      = underrun_q;
    assign fifo_level    = level_q;
endmodule
